// File: rtl/sel2b_pkg.sv
// Shared definitions for the sel2b digit driver: FSM state encoding,
// all-off output constants and the hex-to-segment table (active-low, gfedcba).
package sel2b_pkg;

    // BLANK: all digits dark during dead-time; SHOW: one digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entry n holds the segment pattern for hex digit n. The concatenation lists
    // F first because the leftmost element lands on index 15.
    localparam logic [15:0][6:0] HEX7SEG_TBL = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/sel2b_digit_driver_hex7seg_dec.sv
// Combinational hex digit to 7-segment decoder (active-low, gfedcba).
module hex7seg_dec
    import sel2b_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7SEG_TBL[hex_i];

endmodule

// File: rtl/sel2b_digit_driver.sv
// Four-digit 7-segment driver. A 2-bit selector (SELA = MSB, SELB = LSB),
// asynchronous to IPTCLK, picks which shadow digit is lit. Every digit switch
// inserts BLANK_CYCLES+1 cycles with all digits off so that ghosting cannot
// occur. AN, SEG and BUSY are registered copies of the next-state decode.
// BUSY is high exactly while the FSM is in BLANK, so it doubles as the
// externally visible state bit.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zeros on
// digits 3..1 (digit 0 always shows its value).
module sel2b_digit_driver
    import sel2b_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic        IPTCLK,
    input  logic        IPTRST,
    input  logic        SELA,
    input  logic        SELB,
    input  logic        LOAD,
    input  logic [15:0] DIN,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        BUSY
);

    localparam logic [3:0] CNT_INIT = 4'(BLANK_CYCLES);

    logic [1:0]  sync1_q, sync2_q;
    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        busy_q, busy_d;

    logic [3:0]  digit_d;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_show;

    // Register bank: synchronizer, FSM state, shadow data and output registers.
    always_ff @(posedge IPTCLK) begin
        if (IPTRST) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            state_q  <= BLANK;
            idx_q    <= 2'd0;
            tgt_q    <= 2'd0;
            cnt_q    <= CNT_INIT;
            shadow_q <= 16'h0000;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            busy_q   <= 1'b1;
        end else begin
            sync1_q  <= {SELA, SELB};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            idx_q    <= idx_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: a code change restarts the full dead-time; LOAD is
    // independent of the FSM and is honoured in any state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        shadow_d = LOAD ? DIN : shadow_q;
        case (state_q)
            SHOW: begin
                if (sync2_q != idx_q) begin
                    state_d = BLANK;
                    tgt_d   = sync2_q;
                    cnt_d   = CNT_INIT;
                end
            end
            BLANK: begin
                if (sync2_q != tgt_q) begin
                    tgt_d = sync2_q;
                    cnt_d = CNT_INIT;
                end else if (cnt_q == 4'd0) begin
                    state_d = SHOW;
                    idx_d   = tgt_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = CNT_INIT;
            end
        endcase
    end

    // Digit selected for display in the coming cycle.
    assign digit_d = shadow_d[{idx_d, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .hex_i (digit_d),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Darken a digit when it and every more significant digit are zero.
    always_comb begin
        seg_show = dec_seg;
        case (idx_d)
            2'd3: if (shadow_d[15:12] == 4'h0) seg_show = SEG_OFF;
            2'd2: if (shadow_d[15:8]  == 8'h00) seg_show = SEG_OFF;
            2'd1: if (shadow_d[15:4]  == 12'h000) seg_show = SEG_OFF;
            default: seg_show = dec_seg;
        endcase
    end
`else
    assign seg_show = dec_seg;
`endif

    // Output decode from next state so the registered outputs track the FSM.
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        busy_d = (state_d == BLANK);
        if (state_d == SHOW) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_show;
        end
    end

    assign AN   = an_q;
    assign SEG  = seg_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_sel2b_digit_driver.sv
// Directed bench for sel2b_digit_driver with BLANK_CYCLES=4.
// Honours LEADING_ZERO_BLANK_EN when selecting expected segment patterns.
module tb_sel2b_digit_driver;

    logic        IPTCLK;
    logic        IPTRST;
    logic        SELA;
    logic        SELB;
    logic        LOAD;
    logic [15:0] DIN;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];

    // Expected pattern for a zero digit that has only zero digits above it.
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_ZERO_HI = 7'b1111111;
`else
    localparam logic [6:0] SEG_ZERO_HI = 7'b1000000;
`endif

    sel2b_digit_driver #(.BLANK_CYCLES(4)) dut (
        .IPTCLK (IPTCLK),
        .IPTRST (IPTRST),
        .SELA   (SELA),
        .SELB   (SELB),
        .LOAD   (LOAD),
        .DIN    (DIN),
        .AN     (AN),
        .SEG    (SEG),
        .BUSY   (BUSY)
    );

    // Clock generation.
    initial begin
        IPTCLK = 1'b0;
        forever #5 IPTCLK = ~IPTCLK;
    end

    task automatic step(input int n);
        repeat (n) @(negedge IPTCLK);
    endtask

    task automatic set_code(input logic [1:0] c);
        SELA = c[1];
        SELB = c[0];
    endtask

    task automatic load_word(input logic [15:0] w);
        LOAD = 1'b1;
        DIN  = w;
        step(1);
        LOAD = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Change the code, confirm 2 cycles of old display, 5 dark cycles, then
    // the new digit on the 8th cycle after the change.
    task automatic switch_to(input logic [1:0] c, input logic [3:0] old_an,
                             input logic [3:0] exp_an, input logic [6:0] exp_seg,
                             input string tag);
        set_code(c);
        step(2);
        chk({tag, "_hold_an"}, {12'h0, AN}, {12'h0, old_an});
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk({tag, "_blank_an"}, {12'h0, AN}, 16'h000F);
            chk({tag, "_blank_seg"}, {9'h0, SEG}, 16'h007F);
            chk({tag, "_blank_busy"}, {15'h0, BUSY}, 16'h0001);
        end
        step(1);
        chk({tag, "_an"}, {12'h0, AN}, {12'h0, exp_an});
        chk({tag, "_seg"}, {9'h0, SEG}, {9'h0, exp_seg});
        chk({tag, "_busy"}, {15'h0, BUSY}, 16'h0000);
    endtask

    // Directed sequence.
    initial begin
        IPTRST = 1'b1;
        LOAD   = 1'b0;
        DIN    = 16'h0000;
        set_code(2'd0);
        step(2);
        chk("rst_an", {12'h0, AN}, 16'h000F);
        chk("rst_seg", {9'h0, SEG}, 16'h007F);
        chk("rst_busy", {15'h0, BUSY}, 16'h0001);
        IPTRST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("post_rst_an", {12'h0, AN}, 16'h000F);
            chk("post_rst_busy", {15'h0, BUSY}, 16'h0001);
        end
        step(1);
        chk("first_show_an", {12'h0, AN}, 16'h000E);
        chk("first_show_seg", {9'h0, SEG}, 16'h0040);
        chk("first_show_busy", {15'h0, BUSY}, 16'h0000);

        // Walk through all four digits of 12AF.
        load_word(16'h12AF);
        chk("load_d0_seg", {9'h0, SEG}, 16'h000E);
        exp_q.push_back(7'b0001000);
        exp_q.push_back(7'b0100100);
        exp_q.push_back(7'b1111001);
        switch_to(2'd1, 4'b1110, 4'b1101, exp_q.pop_front(), "walk1");
        switch_to(2'd2, 4'b1101, 4'b1011, exp_q.pop_front(), "walk2");
        switch_to(2'd3, 4'b1011, 4'b0111, exp_q.pop_front(), "walk3");
        switch_to(2'd0, 4'b0111, 4'b1110, 7'b0001110, "walk0");

        // Second change two cycles into BLANK restarts the dead-time.
        set_code(2'd1);
        step(4);
        chk("retgt_busy", {15'h0, BUSY}, 16'h0001);
        set_code(2'd2);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("retgt_blank_an", {12'h0, AN}, 16'h000F);
        end
        step(1);
        chk("retgt_an", {12'h0, AN}, 16'h000B);
        chk("retgt_seg", {9'h0, SEG}, 16'h0024);

        // Back-to-back loads while showing index 0.
        switch_to(2'd0, 4'b1011, 4'b1110, 7'b0001110, "ret0");
        load_word(16'h0000);
        chk("load0_seg", {9'h0, SEG}, 16'h0040);
        load_word(16'h0009);
        chk("load9_seg", {9'h0, SEG}, 16'h0010);

        // Leading-zero behaviour with 0050.
        load_word(16'h0050);
        chk("lz_d0_seg", {9'h0, SEG}, 16'h0040);
        switch_to(2'd1, 4'b1110, 4'b1101, 7'b0010010, "lz1");
        switch_to(2'd2, 4'b1101, 4'b1011, SEG_ZERO_HI, "lz2");
        switch_to(2'd3, 4'b1011, 4'b0111, SEG_ZERO_HI, "lz3");

        // Reset with a simultaneous LOAD while showing index 2.
        switch_to(2'd2, 4'b0111, 4'b1011, SEG_ZERO_HI, "pre_rst2");
        set_code(2'd0);
        IPTRST = 1'b1;
        LOAD   = 1'b1;
        DIN    = 16'hABCD;
        step(1);
        IPTRST = 1'b0;
        LOAD   = 1'b0;
        chk("mid_rst_an", {12'h0, AN}, 16'h000F);
        chk("mid_rst_seg", {9'h0, SEG}, 16'h007F);
        chk("mid_rst_busy", {15'h0, BUSY}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("mid_rst_blank_an", {12'h0, AN}, 16'h000F);
        end
        step(1);
        chk("mid_rst_show_an", {12'h0, AN}, 16'h000E);
        chk("mid_rst_shadow_seg", {9'h0, SEG}, 16'h0040);
        chk("mid_rst_show_busy", {15'h0, BUSY}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
